dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory slave at the far end of the core's load/store port.
- Accepts one load or store request at a time, inserts a programmable number of wait states, then returns a single-cycle dmem_valid completion.
- The core's PC stalls on "load && !dmem_valid"; this block is what generates that dmem_valid.
- Sits beside the core in the 2-stage pipeline top; owns the data RAM array.

Parameters:
- DEPTH, 1024: number of 32-bit words in the RAM.
- ADDR_W, 10: word-index width; must equal clog2(DEPTH).
- WAIT_CYCLES, 2: wait states between request accept and completion (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- dmem_req  input  1  request valid. Held by the core until dmem_valid.
- dmem_we  input  1  1 = store, 0 = load.
- dmem_addr  input  32  byte address. Bits [1:0] are ignored.
- dmem_wdata  input  32  store data.
- dmem_mask  input  4  store byte-lane enables. Bit i enables byte i.
- dmem_valid  output  1  one-cycle completion pulse.
- dmem_rdata  output  32  load data. Registered; valid when dmem_valid=1; holds until the next completion.
- dmem_err  output  1  pulses with dmem_valid when the address was out of range.
- dmem_busy  output  1  high from accept until completion, inclusive.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (clk/rst).
- Reset values: dmem_valid=0, dmem_err=0, dmem_busy=0, dmem_rdata=0, state=IDLE, wait counter=0. RAM contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If dmem_req=1 at a clock edge, capture we, word index (addr[ADDR_W+1:2]), upper address bits, wdata and mask.
  - Load counter=WAIT_CYCLES and set busy=1.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 1, go to RESP.
  - dmem_req and the input buses are not looked at; the captured copy is authoritative. A req deassertion does not abort the transaction.
- Entering RESP (single edge):
  - Perform the access, drive dmem_valid=1, and update dmem_rdata for loads.
  - For stores, the write commits at this edge. Only lanes with mask=1 are written; dmem_rdata is unchanged.
- RESP: valid is high for exactly one cycle, then state returns to IDLE and busy=0.
- Latency: with req first high in cycle 0 while IDLE, dmem_valid is high in cycle WAIT_CYCLES+1.
- Back-to-back requests: a req still high during the RESP cycle belongs to the completing transaction and is not re-accepted. A new request is sampled from the first IDLE cycle onward. Minimum spacing is WAIT_CYCLES+2 cycles.
- Out of range: if addr[31:ADDR_W+2] is non-zero, loads return 0, stores are dropped, and dmem_err=1 alongside valid.
- Loads return the full word; mask is ignored on loads.
- Reset mid-transaction: an abort with no RAM write, even if asserted on the would-be commit edge. Outputs return to reset values.
- Read-after-write to the same word in consecutive transactions returns the new data.
- dmem_busy is combinational from state: (state != IDLE).

Decomposition:
- Shared defines include file holds:
  - state encodings S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2;
  - width constant XLEN=32.
- One natural sub-module: dmem_array, a DEPTH x 32 RAM with 4 byte-lane write enables and a synchronous read port.
- The FSM, counter and capture registers stay in dmem_responder.

Test Plan:
1. WAIT_CYCLES=2: store 0xDEADBEEF, mask 4'b1111, addr 0x10 at cycle 0 -> valid only in cycle 3, err=0. Then load addr 0x10 -> rdata 0xDEADBEEF with valid 3 cycles after accept.
2. Byte lanes: word at 0x20 is 0x11223344; store wdata 0xAABBCCDD, mask 4'b0101 -> a later load returns 0x11BB33DD.
3. Back-to-back: req held high continuously across two loads (0x0, 0x4) -> exactly two valid pulses, at cycles 3 and 7. No extra pulse in either RESP cycle.
4. Out of range: load at 0x0000_1000 with DEPTH=1024 -> valid+err in cycle 3, rdata=0. A store there leaves the RAM unchanged (spot-check 0x0).
5. Reset mid-op: store accepted at cycle 0, rst low at cycle 2 -> valid never pulses, busy=0 immediately, the target word keeps its old value. The next request after reset behaves normally.
6. WAIT_CYCLES=0 rebuild: load accepted at cycle 0 -> valid in cycle 1; req deasserted in cycle 1 still completes normally.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_responder_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_mask;
    logic            dmem_valid;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_err;
    logic            dmem_busy;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
        input  dmem_valid, dmem_rdata, dmem_err, dmem_busy
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask,
        output dmem_valid, dmem_rdata, dmem_err, dmem_busy
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 data RAM with per-byte write enables and a registered read port.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register resets.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one load/store, waits WAIT_CYCLES, then pulses dmem_valid.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cap_en;
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic              oor_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        mask_q;
    logic              valid_q;
    logic              err_q;
    logic              zero_q;

    logic              in_oor;
    logic              live;
    logic              acc_fire;
    logic              acc_we;
    logic              acc_oor;
    logic [ADDR_W-1:0] acc_idx;
    logic [XLEN-1:0]   acc_wdata;
    logic [3:0]        acc_mask;
    logic [3:0]        ram_we;
    logic              ram_re;
    logic [XLEN-1:0]   ram_rdata;
    logic              unused_addr_bits;

    assign in_oor           = |bus.dmem_addr[XLEN-1:ADDR_W+2];
    assign unused_addr_bits = ^bus.dmem_addr[1:0];

    // With zero wait states the access happens on the accept edge, so it must use the live bus.
    assign live      = (state_q == S_IDLE);
    assign acc_we    = live ? bus.dmem_we                 : we_q;
    assign acc_oor   = live ? in_oor                      : oor_q;
    assign acc_idx   = live ? bus.dmem_addr[ADDR_W+1:2]   : idx_q;
    assign acc_wdata = live ? bus.dmem_wdata              : wdata_q;
    assign acc_mask  = live ? bus.dmem_mask               : mask_q;
    assign acc_fire  = (state_d == S_RESP) && (state_q != S_RESP);

    // A reset landing on the commit edge must not let the write through.
    assign ram_we = {4{acc_fire & acc_we & ~acc_oor & rst}} & acc_mask;
    assign ram_re = acc_fire & ~acc_we & ~acc_oor;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.dmem_req) begin
                    cap_en  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= acc_fire;
            err_q   <= acc_fire & acc_oor;
            if (acc_fire && !acc_we) zero_q <= acc_oor;
            if (cap_en) begin
                we_q    <= bus.dmem_we;
                idx_q   <= bus.dmem_addr[ADDR_W+1:2];
                oor_q   <= in_oor;
                wdata_q <= bus.dmem_wdata;
                mask_q  <= bus.dmem_mask;
            end
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    // An out-of-range load masks the RAM read register until the next load completes.
    assign bus.dmem_rdata = zero_q ? '0 : ram_rdata;
    assign bus.dmem_valid = valid_q;
    assign bus.dmem_err   = err_q;
    assign bus.dmem_busy  = (state_q != S_IDLE);

endmodule
